// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM arbiter: owner states, master
// indices and the byte-select code width.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_LSU    = 1'b1;

  localparam int SEL_W = 3;

endpackage

// File: rtl/wb_ram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single-port RAM.
// Ownership lasts for a whole CYC; ACKs are routed only to the current owner.
module wb_ram_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 32,
  parameter int LGPIPE = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_m0_cyc,
  input  logic             i_m0_stb,
  input  logic             i_m0_we,
  input  logic [AW-1:0]    i_m0_addr,
  input  logic [XLEN-1:0]  i_m0_data,
  input  logic [SEL_W-1:0] i_m0_sel,
  output logic             o_m0_stall,
  output logic             o_m0_ack,
  output logic [XLEN-1:0]  o_m0_data,
  input  logic             i_m1_cyc,
  input  logic             i_m1_stb,
  input  logic             i_m1_we,
  input  logic [AW-1:0]    i_m1_addr,
  input  logic [XLEN-1:0]  i_m1_data,
  input  logic [SEL_W-1:0] i_m1_sel,
  output logic             o_m1_stall,
  output logic             o_m1_ack,
  output logic [XLEN-1:0]  o_m1_data,
  output logic             o_s_stb,
  output logic             o_s_we,
  output logic [AW-1:0]    o_s_addr,
  output logic [XLEN-1:0]  o_s_data,
  output logic [SEL_W-1:0] o_s_sel,
  input  logic [XLEN-1:0]  i_s_data,
  input  logic             i_s_ack,
  input  logic             i_s_stall
);

  // All-ones in LGPIPE bits is the in-flight ceiling, 2^LGPIPE-1.
  localparam logic [LGPIPE-1:0] CNT_MAX = '1;

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [LGPIPE-1:0] outstanding_q, outstanding_d;

  logic own0, own1;
  logic owner_cyc, owner_stb;
  logic full, accept, retire, ack_ok;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  assign owner_cyc = (own0 & i_m0_cyc) | (own1 & i_m1_cyc);
  assign owner_stb = (own0 & i_m0_stb) | (own1 & i_m1_stb);

  assign full    = (outstanding_q == CNT_MAX);
  assign o_s_stb = owner_cyc & owner_stb & ~full;
  assign accept  = o_s_stb & ~i_s_stall;
  assign retire  = i_s_ack & (outstanding_q != '0);

  // A cleared counter after release is what drops late ACKs of the old owner.
  assign ack_ok   = i_s_ack & owner_cyc & (outstanding_q != '0);
  assign o_m0_ack = ack_ok & own0;
  assign o_m1_ack = ack_ok & own1;

  assign o_m0_stall = own0 ? (i_s_stall | full) : 1'b1;
  assign o_m1_stall = own1 ? (i_s_stall | full) : 1'b1;

  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so a
    // missed branch can never leave a latch behind.
    o_s_we   = i_m0_we;
    o_s_addr = i_m0_addr;
    o_s_data = i_m0_data;
    o_s_sel  = i_m0_sel;
    if (own1) begin
      o_s_we   = i_m1_we;
      o_s_addr = i_m1_addr;
      o_s_data = i_m1_data;
      o_s_sel  = i_m1_sel;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    outstanding_d = outstanding_q;

    unique case ({accept, retire})
      2'b10:   outstanding_d = outstanding_q + LGPIPE'(1);
      2'b01:   outstanding_d = outstanding_q - LGPIPE'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_d = last_q ? OWN0 : OWN1;
        else if (i_m0_cyc)        state_d = OWN0;
        else if (i_m1_cyc)        state_d = OWN1;
      end
      OWN0: begin
        if (!i_m0_cyc) begin
          state_d       = i_m1_cyc ? OWN1 : IDLE;
          last_d        = M_IFETCH;
          outstanding_d = '0;
        end
      end
      OWN1: begin
        if (!i_m1_cyc) begin
          state_d       = i_m0_cyc ? OWN0 : IDLE;
          last_d        = M_LSU;
          outstanding_d = '0;
        end
      end
      default: begin
        state_d       = IDLE;
        outstanding_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      last_q        <= M_LSU;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
